add16_rr_arbiter: RTL

- Shares one Add16 instance (16-bit, no carry-in, no carry-out) among NREQ requesters.
- Round-robin arbitration. Per-requester valid/ready request handshake and a single valid/ready response channel.
- One operation in flight at a time. The response is tagged with the winning requester's index.
- Sits between the ALU-side clients and the shared adder datapath.

---
 rtl/add16_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/add16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder among NREQ requesters.
// Optional rsp_carry output is enabled by defining ADD16_RR_ARBITER_CARRY_EN.

module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module add16_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id
`ifdef ADD16_RR_ARBITER_CARRY_EN
  ,
  output logic               rsp_carry
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic [15:0]    sum;

  logic           found;
  logic [IDW-1:0] win_id;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;
  int             idx;

  add16 u_add16 (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // Search upward from rr_ptr, wrapping, so the previous winner ranks last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found  = 1'b0;
    win_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
        sel_a  = req_a[16*idx +: 16];
        sel_b  = req_b[16*idx +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win_id] = 1'b1;
  end

`ifdef ADD16_RR_ARBITER_CARRY_EN
  logic carry;
  assign carry = (op_a[15] & op_b[15]) | ((op_a[15] ^ op_b[15]) & ~sum[15]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef ADD16_RR_ARBITER_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            gnt_id <= win_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= sum;
          rsp_id    <= gnt_id;
          rsp_valid <= 1'b1;
`ifdef ADD16_RR_ARBITER_CARRY_EN
          rsp_carry <= carry;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
